cordic_div_arbiter: RTL and testbench
=====================================

Name: cordic_div_arbiter

Overview:
Shares one CORDIC linear-mode divider among NUM_REQ requesters (neuron activation/normalisation units). Round-robin arbitration, per-requester valid/ready intake, single-operation sequencing of the divider (start pulse, wait for done, watchdog) and a tagged response channel with backpressure. Sits between the neuron datapath lanes and the shared divider core.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
DATA_W, 8, operand/quotient width, two's complement.
ID_W, 2, response tag width; must equal ceil(log2(NUM_REQ)).
TIMEOUT, 32, max divider cycles after start before forced error response (>=2).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
req_dividend  in  NUM_REQ*DATA_W  packed; requester i at bits [i*DATA_W +: DATA_W].
req_divisor  in  NUM_REQ*DATA_W  packed, same layout.
div_start  out  1  one-cycle launch pulse to divider.
div_dividend  out  DATA_W  operand to divider; stable from ISSUE until RESP.
div_divisor  out  DATA_W  operand to divider; stable from ISSUE until RESP.
div_done  in  1  divider result valid (pulse or level; sampled only in WAIT).
div_q  in  DATA_W  divider quotient.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response consumer accept.
rsp_id  out  ID_W  index of requester owning the response.
rsp_q  out  DATA_W  quotient.
rsp_err  out  1  1 = watchdog expired (or div-by-zero when the optional feature is on).

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, rr_ptr=0, wdog=0; all outputs 0 (req_ready, div_start, div_dividend, div_divisor, rsp_valid, rsp_id, rsp_q, rsp_err).
- FSM states: IDLE, ISSUE, WAIT, RESP. One operation in flight, no queue.
- IDLE: grant g = first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. req_ready[g]=1 combinationally in the same cycle. No other req_ready bit is set. On the handshake edge, latch g and both operands into div_*. Then go to ISSUE. If no req_valid bits are set, stay in IDLE.
- req_ready is 0 in every state except IDLE. Requesters must hold valid and operands until accepted. Valid must not depend on ready.
- ISSUE: div_start=1 for exactly this cycle. Clear wdog to 0. Then go to WAIT.
- WAIT: wdog increments each cycle.
  - If div_done=1: latch rsp_q=div_q, rsp_err=0, go to RESP.
  - Else if wdog==TIMEOUT-1: rsp_q=0, rsp_err=1, go to RESP.
  - If div_done and the timeout hit in the same cycle, done wins.
- div_done outside WAIT is ignored.
- RESP: rsp_valid=1 and rsp_id=g. rsp_q and rsp_err stay stable until rsp_ready=1. On the handshake edge: rr_ptr=(g+1) mod NUM_REQ, rsp_valid cleared, go to IDLE.
  - No new grant is made in the handshake cycle, so the minimum spacing between grants is 3 cycles plus divider latency.
- rr_ptr advances only on response completion, never on a timeout-free idle cycle. A requester that drops valid simply loses its turn.
- Fairness: a continuously requesting requester is served within NUM_REQ operations.
- Operands pass through unmodified. Sign handling belongs to the divider.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Any in-flight divider result is discarded, and a later div_done is ignored.

Optional Feature:
Macro CORDIC_DIVZ_BYPASS_EN.
- Defined: in IDLE, an accepted request whose divisor is 0 skips ISSUE and WAIT and goes straight to RESP. Response is rsp_err=1 with rsp_q saturated: 0x7F (+max) if the dividend is >=0, 0x80 (-max) if negative, for DATA_W=8. No div_start is issued.
- Not defined: divisor 0 is sent to the divider like any other operand. Only the watchdog can flag it.

Test Plan:
- Single request: req0 dividend=12, divisor=3; bench divider model returns 4 after 7 cycles -> one div_start pulse; rsp_valid with rsp_id=0, rsp_q=4, rsp_err=0; req_ready[0] high for exactly one cycle.
- Round robin: all 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; rsp_id sequence matches; never two req_ready bits set.
- Backpressure: rsp_ready=0 for 10 cycles with rsp_valid up -> rsp_q/rsp_id/rsp_err stable; req_ready stays 0; completes on the rsp_ready cycle, then returns to IDLE.
- Watchdog: divider model never asserts div_done -> rsp_err=1 and rsp_q=0 exactly TIMEOUT cycles after the ISSUE cycle. A div_done on the timeout cycle instead gives rsp_err=0.
- Reset mid-WAIT: assert rst_n=0 during WAIT -> all outputs 0 asynchronously. A late div_done after release produces no response, and the first grant after reset goes to requester 0.
- With CORDIC_DIVZ_BYPASS_EN: req2 dividend=-5, divisor=0 -> no div_start; rsp_id=2, rsp_q=0x80, rsp_err=1. Without the macro, a div_start is issued.

Source files
------------

// File: rtl/cordic_div_arbiter.sv
// Round-robin arbiter sharing one CORDIC linear-mode divider among NUM_REQ requesters.
// Optional macro CORDIC_DIVZ_BYPASS_EN: zero-divisor requests are answered directly (saturated, err).
module cordic_div_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_dividend,
    input  logic [NUM_REQ*DATA_W-1:0] req_divisor,
    output logic                      div_start,
    output logic [DATA_W-1:0]         div_dividend,
    output logic [DATA_W-1:0]         div_divisor,
    input  logic                      div_done,
    input  logic [DATA_W-1:0]         div_q,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_q,
    output logic                      rsp_err
);

    localparam int unsigned WDOG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [ID_W-1:0]     gid_q, gid_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic [DATA_W-1:0]   rq_q, rq_d;
    logic                rerr_q, rerr_d;

    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     cand;
    logic [DATA_W-1:0]   sel_dividend;
    logic [DATA_W-1:0]   sel_divisor;

    // Rotating priority search starting at rr_q.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = ID_W'((32'(rr_q) + 32'(k)) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign sel_dividend = req_dividend[grant_idx*DATA_W +: DATA_W];
    assign sel_divisor  = req_divisor[grant_idx*DATA_W +: DATA_W];

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gid_d     = gid_q;
        wdog_d    = wdog_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rq_d      = rq_q;
        rerr_d    = rerr_q;
        req_ready = '0;
        div_start = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    gid_d                = grant_idx;
                    dvd_d                = sel_dividend;
                    dvs_d                = sel_divisor;
`ifdef CORDIC_DIVZ_BYPASS_EN
                    if (sel_divisor == '0) begin
                        // Saturate toward the sign of the dividend; divider never launched.
                        rq_d    = sel_dividend[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                                         : {1'b0, {(DATA_W-1){1'b1}}};
                        rerr_d  = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StIssue;
                    end
`else
                    state_d = StIssue;
`endif
                end
            end
            StIssue: begin
                div_start = 1'b1;
                wdog_d    = '0;
                state_d   = StWait;
            end
            StWait: begin
                wdog_d = wdog_q + WDOG_W'(1);
                // A done arriving on the timeout cycle still wins.
                if (div_done) begin
                    rq_d    = div_q;
                    rerr_d  = 1'b0;
                    state_d = StResp;
                end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                    rq_d    = '0;
                    rerr_d  = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rr_d    = (32'(gid_q) == NUM_REQ - 1) ? '0 : gid_q + ID_W'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rr_q    <= '0;
            gid_q   <= '0;
            wdog_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rq_q    <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gid_q   <= gid_d;
            wdog_q  <= wdog_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rq_q    <= rq_d;
            rerr_q  <= rerr_d;
        end
    end

    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign rsp_valid    = (state_q == StResp);
    assign rsp_id       = gid_q;
    assign rsp_q        = rq_q;
    assign rsp_err      = rerr_q;

endmodule

// File: tb/tb_cordic_div_arbiter.sv
// Scoreboard bench for cordic_div_arbiter with a behavioural divider of programmable latency.
module tb_cordic_div_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 32;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_dividend;
    logic [NUM_REQ*DATA_W-1:0] req_divisor;
    logic                      div_start;
    logic [DATA_W-1:0]         div_dividend;
    logic [DATA_W-1:0]         div_divisor;
    logic                      div_done;
    logic [DATA_W-1:0]         div_q;
    logic                      rsp_valid;
    logic                      rsp_ready = 1'b1;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_q;
    logic                      rsp_err;

    always #5 clk = ~clk;

    cordic_div_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .ID_W   (ID_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dividend(req_dividend),
        .req_divisor (req_divisor),
        .div_start   (div_start),
        .div_dividend(div_dividend),
        .div_divisor (div_divisor),
        .div_done    (div_done),
        .div_q       (div_q),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_q       (rsp_q),
        .rsp_err     (rsp_err)
    );

    // Requester slots: one pending op per requester; auto re-presents a new op after acceptance.
    logic [NUM_REQ-1:0] pend = '0;
    logic [NUM_REQ-1:0] auto_fill = '0;
    logic [DATA_W-1:0]  op_a [NUM_REQ];
    logic [DATA_W-1:0]  op_b [NUM_REQ];

    assign req_valid = pend;
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_dividend[i*DATA_W +: DATA_W] = op_a[i];
            req_divisor[i*DATA_W +: DATA_W]  = op_b[i];
        end
    end

    // Divider model: done visible dm_lat cycles after the start cycle; zero divisor never answers.
    logic              dm_busy;
    int                dm_cnt;
    logic [DATA_W-1:0] dm_a, dm_b;
    int                dm_lat = 7;
    logic              dm_never = 1'b0;
    logic              dm_kick = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_busy  <= 1'b0;
            dm_cnt   <= 0;
            dm_a     <= '0;
            dm_b     <= '0;
            div_done <= 1'b0;
            div_q    <= '0;
        end else begin
            div_done <= 1'b0;
            if (dm_kick) begin
                div_done <= 1'b1;
                div_q    <= 8'h55;
            end else if (div_start) begin
                dm_busy <= !dm_never && (div_divisor != '0);
                dm_cnt  <= 1;
                dm_a    <= div_dividend;
                dm_b    <= div_divisor;
            end else if (dm_busy) begin
                if (dm_cnt + 1 == dm_lat) begin
                    div_done <= 1'b1;
                    div_q    <= 8'($signed(dm_a) / $signed(dm_b));
                    dm_busy  <= 1'b0;
                end
                dm_cnt <= dm_cnt + 1;
            end
        end
    end

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] q;
        logic              err;
    } exp_t;

    exp_t sb[$];
    int   id_log[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t expect_of(input int i, input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
        exp_t e;
        e.id = ID_W'(i);
        if (b == '0) begin
`ifdef CORDIC_DIVZ_BYPASS_EN
            e.q = a[DATA_W-1] ? 8'h80 : 8'h7f;
`else
            e.q = 8'h00;
`endif
            e.err = 1'b1;
        end else if (dm_never || dm_lat > TIMEOUT) begin
            e.q   = 8'h00;
            e.err = 1'b1;
        end else begin
            e.q   = 8'($signed(a) / $signed(b));
            e.err = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [63:0] outs();
        return 64'({req_ready, div_start, div_dividend, div_divisor,
                    rsp_valid, rsp_id, rsp_q, rsp_err});
    endfunction

    // Monitor state, all updated from the single stimulus thread.
    int   cycle = 0;
    int   starts = 0;
    int   r0_cnt = 0;
    int   rsp_cnt = 0;
    int   start_cyc = 0;
    int   rise_cyc = 0;
    int   onehot_viol = 0;
    int   stab_viol = 0;
    int   rdy_in_resp = 0;
    logic prev_valid = 1'b0;
    logic prev_hs = 1'b0;
    exp_t hold;

    // One clock: sample at negedge+1, then apply acceptances after the posedge.
    task automatic step();
        logic [NUM_REQ-1:0] acc;
        exp_t e;
        #1;
        acc = req_valid & req_ready;
        if ($countones(req_ready) > 1) onehot_viol++;
        if (div_start) begin
            starts++;
            start_cyc = cycle;
        end
        if (req_ready[0]) r0_cnt++;
        if (rsp_valid) begin
            rsp_cnt++;
            if (!prev_valid) rise_cyc = cycle;
            if (prev_valid && !prev_hs &&
                (rsp_id !== hold.id || rsp_q !== hold.q || rsp_err !== hold.err)) stab_viol++;
            if (req_ready != '0) rdy_in_resp++;
            hold = '{id: rsp_id, q: rsp_q, err: rsp_err};
            if (rsp_ready) begin
                id_log.push_back(int'(rsp_id));
                if (sb.size() == 0) begin
                    check("sb_unexpected_rsp", 64'(rsp_id), 64'hffff);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                    check("rsp_q", 64'(rsp_q), 64'(e.q));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                end
            end
        end
        prev_valid = rsp_valid;
        prev_hs    = rsp_valid && rsp_ready;
        cycle++;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) begin
                sb.push_back(expect_of(i, op_a[i], op_b[i]));
                if (auto_fill[i]) op_a[i] = op_a[i] + 8'd1;
                else pend[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((sb.size() != 0 || pend != '0 || rsp_valid) && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(n < budget), 64'd1);
    endtask

    task automatic do_reset(input string tag);
        rst_n     = 1'b0;
        pend      = '0;
        auto_fill = '0;
        sb.delete();
        #1;
        check(tag, outs(), 64'd0);
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic submit(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        op_a[i] = a;
        op_b[i] = b;
        pend[i] = 1'b1;
    endtask

    initial begin
        int n;
        int rr_exp[5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        @(negedge clk);
        do_reset("reset_outputs");

        // Single request, divider latency 7.
        starts = 0; r0_cnt = 0; dm_lat = 7;
        submit(0, 8'd12, 8'd3);
        drain("single_drain", 100);
        check("single_starts", 64'(starts), 64'd1);
        check("single_ready_cycles", 64'(r0_cnt), 64'd1);
        check("single_latency", 64'(rise_cyc - start_cyc - 1), 64'd7);

        // Round robin from a fresh pointer, all requesters continuously valid.
        do_reset("reset_before_rr");
        dm_lat = 3;
        id_log.delete();
        for (int i = 0; i < NUM_REQ; i++) submit(i, 8'(20 + i), 8'(i + 2));
        auto_fill = '1;
        n = 0;
        while (id_log.size() < 5 && n < 200) begin
            step();
            n++;
        end
        pend      = '0;
        auto_fill = '0;
        check("rr_count", 64'(id_log.size() >= 5), 64'd1);
        for (int k = 0; k < 5 && k < id_log.size(); k++) check("rr_order", 64'(id_log[k]), 64'(rr_exp[k]));
        sb.delete();
        drain("rr_drain", 50);

        // Backpressure: hold the response for 10 cycles.
        rsp_ready = 1'b0;
        submit(2, 8'hd8, 8'd5);
        n = 0;
        while (!rsp_valid && n < 100) begin
            step();
            n++;
        end
        check("bp_valid_seen", 64'(rsp_valid), 64'd1);
        repeat (10) step();
        check("bp_still_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        drain("bp_drain", 20);
        check("bp_idle_after", 64'(rsp_valid), 64'd0);

        // Watchdog with a silent divider, then done landing on the timeout cycle.
        dm_never = 1'b1;
        submit(3, 8'd7, 8'd1);
        drain("wd_drain", 100);
        check("wd_wait_cycles", 64'(rise_cyc - start_cyc - 1), 64'(TIMEOUT));
        dm_never = 1'b0;
        dm_lat   = TIMEOUT;
        submit(0, 8'd9, 8'd3);
        drain("wd_edge_drain", 100);
        check("wd_edge_wait_cycles", 64'(rise_cyc - start_cyc - 1), 64'(TIMEOUT));

        // Divide by zero.
        dm_lat = 3;
        starts = 0;
        submit(2, 8'hfb, 8'd0);
        drain("divz_drain", 100);
`ifdef CORDIC_DIVZ_BYPASS_EN
        check("divz_starts", 64'(starts), 64'd0);
`else
        check("divz_starts", 64'(starts), 64'd1);
`endif

        // Leave rr pointer at 3, then reset during WAIT of a requester-1 op.
        submit(2, 8'd10, 8'd2);
        drain("pre_rst_drain", 50);
        dm_never = 1'b1;
        starts   = 0;
        submit(1, 8'd30, 8'd3);
        n = 0;
        while (starts == 0 && n < 20) begin
            step();
            n++;
        end
        check("mid_issue_seen", 64'(starts), 64'd1);
        repeat (3) step();
        do_reset("reset_mid_wait");
        dm_never = 1'b0;
        rsp_cnt  = 0;
        dm_kick  = 1'b1;
        step();
        dm_kick = 1'b0;
        repeat (5) step();
        check("late_done_ignored", 64'(rsp_cnt), 64'd0);
        submit(0, 8'd40, 8'd8);
        submit(3, 8'd50, 8'd5);
        #1;
        check("post_reset_grant", 64'(req_ready), 64'b0001);
        drain("post_reset_drain", 100);

        check("ready_onehot", 64'(onehot_viol), 64'd0);
        check("rsp_stable", 64'(stab_viol), 64'd0);
        check("ready_in_resp", 64'(rdy_in_resp), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
